// File: rtl/crack_sched.sv
// Key-search scheduler: hands out trial keys to two crack cores, collects the
// smallest found key, and round-robin arbitrates the shared ct read port.
//
// state | meaning
// IDLE  | after reset, waiting for en
// RUN   | dispatching trial keys to free cores
// DRAIN | no more dispatch, waiting for in-flight trials to finish
// DONE  | result presented on key/key_valid, waiting for en
module crack_sched #(
  parameter logic [23:0] KEY_MAX = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  output logic        key_valid,
  output logic [23:0] key,
  output logic        c0_en,
  output logic        c1_en,
  output logic [23:0] c0_key,
  output logic [23:0] c1_key,
  input  logic        c0_done,
  input  logic        c1_done,
  input  logic        c0_found,
  input  logic        c1_found,
  input  logic        c0_ct_req,
  input  logic        c1_ct_req,
  input  logic [7:0]  c0_ct_addr,
  input  logic [7:0]  c1_ct_addr,
  output logic        c0_ct_gnt,
  output logic        c1_ct_gnt,
  output logic [7:0]  ct_addr
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      r_state;
  logic [24:0] r_next_key;
  logic        r_busy0, r_busy1;
  logic        r_cand_vld;
  logic [23:0] r_cand;
  logic        r_key_valid;
  logic [23:0] r_key;
  logic        r_c0_en, r_c1_en;
  logic [23:0] r_c0_key, r_c1_key;
  logic        r_gnt0, r_gnt1;
  logic [7:0]  r_ct_addr;
  logic        r_prio1;

  logic [24:0] w_max, w_nk1, w_k1, w_nk_next;
  logic        w_done0, w_done1, w_found0, w_found1;
  logic        w_disp_ok, w_d0, w_d1;
  logic        w_cand_vld_n;
  logic [23:0] w_cand_n;
  logic        w_g0, w_g1;

  assign w_max    = {1'b0, KEY_MAX};
  assign w_done0  = c0_done & r_busy0;
  assign w_done1  = c1_done & r_busy1;
  assign w_found0 = w_done0 & c0_found;
  assign w_found1 = w_done1 & c1_found;

  // Dispatch uses the registered busy flags, so a core freed this cycle waits one cycle.
  assign w_nk1     = r_next_key + 25'd1;
  assign w_disp_ok = (r_state == S_RUN) && !w_found0 && !w_found1;
  assign w_d0      = w_disp_ok && !r_busy0 && (r_next_key <= w_max);
  assign w_k1      = w_d0 ? w_nk1 : r_next_key;
  assign w_d1      = w_disp_ok && !r_busy1 && (w_k1 <= w_max);
  assign w_nk_next = r_next_key + {24'd0, w_d0} + {24'd0, w_d1};

  always_comb begin
    w_cand_n     = r_cand;
    w_cand_vld_n = r_cand_vld;
    if (w_found0 && (!w_cand_vld_n || r_c0_key < w_cand_n)) begin
      w_cand_n     = r_c0_key;
      w_cand_vld_n = 1'b1;
    end
    if (w_found1 && (!w_cand_vld_n || r_c1_key < w_cand_n)) begin
      w_cand_n     = r_c1_key;
      w_cand_vld_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_next_key  <= '0;
      r_busy0     <= 1'b0;
      r_busy1     <= 1'b0;
      r_cand_vld  <= 1'b0;
      r_cand      <= '0;
      r_key_valid <= 1'b0;
      r_key       <= '0;
      r_c0_en     <= 1'b0;
      r_c1_en     <= 1'b0;
      r_c0_key    <= '0;
      r_c1_key    <= '0;
    end else begin
      r_c0_en    <= 1'b0;
      r_c1_en    <= 1'b0;
      r_busy0    <= (r_busy0 & ~w_done0) | w_d0;
      r_busy1    <= (r_busy1 & ~w_done1) | w_d1;
      r_cand     <= w_cand_n;
      r_cand_vld <= w_cand_vld_n;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (en) begin
            r_state     <= S_RUN;
            r_next_key  <= '0;
            r_key_valid <= 1'b0;
            r_busy0     <= 1'b0;
            r_busy1     <= 1'b0;
            r_cand_vld  <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_d0) begin
            r_c0_en  <= 1'b1;
            r_c0_key <= r_next_key[23:0];
          end
          if (w_d1) begin
            r_c1_en  <= 1'b1;
            r_c1_key <= w_k1[23:0];
          end
          r_next_key <= w_nk_next;
          if (w_found0 || w_found1 || (w_nk_next > w_max))
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!r_busy0 && !r_busy1) begin
            r_state     <= S_DONE;
            r_key_valid <= r_cand_vld;
            if (r_cand_vld)
              r_key <= r_cand;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ct port: on contention the core that did not win last time goes first.
  assign w_g0 = c0_ct_req && (!c1_ct_req || !r_prio1);
  assign w_g1 = c1_ct_req && !w_g0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_ct_addr <= '0;
      r_prio1   <= 1'b0;
    end else begin
      r_gnt0    <= w_g0;
      r_gnt1    <= w_g1;
      r_ct_addr <= w_g0 ? c0_ct_addr : (w_g1 ? c1_ct_addr : 8'd0);
      if (w_g0)
        r_prio1 <= 1'b1;
      else if (w_g1)
        r_prio1 <= 1'b0;
    end
  end

  assign rdy       = (r_state == S_IDLE) || (r_state == S_DONE);
  assign key_valid = r_key_valid;
  assign key       = r_key;
  assign c0_en     = r_c0_en;
  assign c1_en     = r_c1_en;
  assign c0_key    = r_c0_key;
  assign c1_key    = r_c1_key;
  assign c0_ct_gnt = r_gnt0;
  assign c1_ct_gnt = r_gnt1;
  assign ct_addr   = r_ct_addr;

endmodule

// File: tb/tb_crack_sched.sv
// Scoreboard bench for crack_sched with KEY_MAX=5: two behavioural cores with
// per-key latency and found tables, plus directed ct-arbiter and reset cases.
module tb_crack_sched;

  logic        clk, rst_n, en;
  logic        rdy, key_valid;
  logic [23:0] key, c0_key, c1_key;
  logic        c0_en, c1_en;
  logic        c0_done, c1_done, c0_found, c1_found;
  logic        c0_ct_req, c1_ct_req;
  logic [7:0]  c0_ct_addr, c1_ct_addr, ct_addr;
  logic        c0_ct_gnt, c1_ct_gnt;

  crack_sched #(.KEY_MAX(24'd5)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
    .key_valid(key_valid), .key(key),
    .c0_en(c0_en), .c1_en(c1_en), .c0_key(c0_key), .c1_key(c1_key),
    .c0_done(c0_done), .c1_done(c1_done),
    .c0_found(c0_found), .c1_found(c1_found),
    .c0_ct_req(c0_ct_req), .c1_ct_req(c1_ct_req),
    .c0_ct_addr(c0_ct_addr), .c1_ct_addr(c1_ct_addr),
    .c0_ct_gnt(c0_ct_gnt), .c1_ct_gnt(c1_ct_gnt), .ct_addr(ct_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [24:0] exp_disp[$];   // {core, key}
  logic [24:0] exp_done[$];   // {key_valid, key}
  logic [8:0]  exp_gnt[$];    // {core, addr}

  int         lat_tab[8];
  logic [7:0] find_mask;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural cores: done (with found from find_mask) lat_tab[key] cycles after dispatch.
  int          cnt0 = 0, cnt1 = 0;
  logic [23:0] k0 = '0, k1 = '0;
  always @(posedge clk) begin
    #1;
    c0_done = 1'b0; c0_found = 1'b0;
    c1_done = 1'b0; c1_found = 1'b0;
    if (cnt0 > 0) begin
      cnt0--;
      if (cnt0 == 0) begin
        c0_done  = 1'b1;
        c0_found = (k0 < 24'd8) && find_mask[k0[2:0]];
      end
    end
    if (cnt1 > 0) begin
      cnt1--;
      if (cnt1 == 0) begin
        c1_done  = 1'b1;
        c1_found = (k1 < 24'd8) && find_mask[k1[2:0]];
      end
    end
    if (c0_en) begin k0 = c0_key; cnt0 = lat_tab[k0[2:0]]; end
    if (c1_en) begin k1 = c1_key; cnt1 = lat_tab[k1[2:0]]; end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a dispatch, result or grant.
  logic prev_rdy = 1'b1;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rdy = 1'b1;
    end else begin
      if (c0_en) begin
        if (exp_disp.size() == 0) chk("disp_unexpected_c0", 32'(c0_key), 32'hFFFFFFFF);
        else chk("disp_c0", 32'({1'b0, c0_key}), 32'(exp_disp.pop_front()));
      end
      if (c1_en) begin
        if (exp_disp.size() == 0) chk("disp_unexpected_c1", 32'(c1_key), 32'hFFFFFFFF);
        else chk("disp_c1", 32'({1'b1, c1_key}), 32'(exp_disp.pop_front()));
      end
      if (rdy && !prev_rdy) begin
        if (exp_done.size() == 0) chk("done_unexpected", 32'(key_valid), 32'hFFFFFFFF);
        else chk("result", 32'({key_valid, key_valid ? key : 24'd0}), 32'(exp_done.pop_front()));
      end
      if (c0_ct_gnt || c1_ct_gnt) begin
        chk("gnt_onehot", 32'(c0_ct_gnt & c1_ct_gnt), 32'd0);
        if (exp_gnt.size() == 0) chk("gnt_unexpected", 32'({c1_ct_gnt, ct_addr}), 32'hFFFFFFFF);
        else chk("gnt", 32'({c1_ct_gnt, ct_addr}), 32'(exp_gnt.pop_front()));
      end else begin
        chk("ct_addr_idle", 32'(ct_addr), 32'd0);
      end
      prev_rdy = rdy;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start();
    en = 1'b1;
    idle(1);
    en = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!rdy && n < 200) begin idle(1); n++; end
    chk({nm, "_reached_done"}, 32'(rdy), 32'd1);
    idle(2);
  endtask

  task automatic set_lat(input int l);
    for (int i = 0; i < 8; i++) lat_tab[i] = l;
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_rdy"},       32'(rdy), 32'd1);
    chk({nm, "_key_valid"}, 32'(key_valid), 32'd0);
    chk({nm, "_key"},       32'(key), 32'd0);
    chk({nm, "_cen"},       32'({c0_en, c1_en}), 32'd0);
    chk({nm, "_c0_key"},    32'(c0_key), 32'd0);
    chk({nm, "_c1_key"},    32'(c1_key), 32'd0);
    chk({nm, "_gnt"},       32'({c0_ct_gnt, c1_ct_gnt}), 32'd0);
    chk({nm, "_ct_addr"},   32'(ct_addr), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0;
    c0_done = 1'b0; c1_done = 1'b0; c0_found = 1'b0; c1_found = 1'b0;
    c0_ct_req = 1'b0; c1_ct_req = 1'b0; c0_ct_addr = '0; c1_ct_addr = '0;
    set_lat(1); find_mask = '0;
    #2;
    check_reset("por");
    #10 rst_n = 1'b1;
    idle(2);

    // Core1 finds 3 while core0 is still on 2; core0 later finds 2 -> 2 wins.
    set_lat(1); lat_tab[2] = 6; lat_tab[3] = 2; find_mask = 8'b0000_1100;
    exp_disp.push_back({1'b0, 24'd0}); exp_disp.push_back({1'b1, 24'd1});
    exp_disp.push_back({1'b0, 24'd2}); exp_disp.push_back({1'b1, 24'd3});
    exp_done.push_back({1'b1, 24'd2});
    start();
    wait_done("found_late_smaller");
    chk("b_key_hold", 32'({key_valid, key}), 32'({1'b1, 24'd2}));

    // Restart from DONE; both cores find 4 and 5 in the same cycle -> 4.
    set_lat(1); find_mask = 8'b0011_0000;
    for (int i = 0; i < 6; i++) exp_disp.push_back({i[0], 24'(i)});
    exp_done.push_back({1'b1, 24'd4});
    start();
    chk("restart_key_valid_clr", 32'(key_valid), 32'd0);
    chk("restart_rdy_low", 32'(rdy), 32'd0);
    wait_done("both_found");

    // Reset in the middle of RUN while keys 2/3 are in flight.
    set_lat(3); find_mask = '0;
    for (int i = 0; i < 4; i++) exp_disp.push_back({i[0], 24'(i)});
    start();
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset("mid_run_rst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    idle(5);
    chk("post_rst_idle_rdy", 32'(rdy), 32'd1);

    // Full no-find sweep of keys 0..5; an en pulse during RUN must be ignored.
    set_lat(3); find_mask = '0;
    for (int i = 0; i < 6; i++) exp_disp.push_back({i[0], 24'(i)});
    exp_done.push_back({1'b0, 24'd0});
    start();
    idle(2);
    en = 1'b1;
    idle(1);
    en = 1'b0;
    wait_done("sweep_no_find");
    chk("sweep_key_valid", 32'(key_valid), 32'd0);

    // ct arbiter: both requesting for 6 cycles, then each core alone.
    c0_ct_addr = 8'h11; c1_ct_addr = 8'h22;
    for (int i = 0; i < 6; i++) exp_gnt.push_back(i[0] ? {1'b1, 8'h22} : {1'b0, 8'h11});
    c0_ct_req = 1'b1; c1_ct_req = 1'b1;
    idle(6);
    exp_gnt.push_back({1'b1, 8'h22});
    c0_ct_req = 1'b0;
    idle(1);
    exp_gnt.push_back({1'b0, 8'h11});
    c0_ct_req = 1'b1; c1_ct_req = 1'b0;
    idle(1);
    c0_ct_req = 1'b0;
    idle(3);

    chk("disp_queue_empty", 32'(exp_disp.size()), 32'd0);
    chk("done_queue_empty", 32'(exp_done.size()), 32'd0);
    chk("gnt_queue_empty",  32'(exp_gnt.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
